clz_pipe: RTL and testbench

CLZ_PIPE -- requirements
Module: clz_pipe

---
 rtl/clz_pkg.sv | 13 +
 rtl/clz_nib.sv | 21 ++
 rtl/clz_pipe.sv | 169 ++++++++++++++++
 tb/tb_clz_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clz_pkg.sv
// Shared constants for the count-leading-zeros/sign pipeline.
// Holds the mode encodings and the count-width helper used to size the count.
package clz_pkg;

    localparam logic CLZ_MODE_CLZ = 1'b0;
    localparam logic CLZ_MODE_CLS = 1'b1;

    // Width of a count that must represent every value 0..width inclusive.
    function automatic int clz_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/clz_nib.sv
// 4-bit leading-zero encoder. The count is 0..3 for a non-zero nibble.
// Bit 2 of the count set (value 4) means the nibble is all zeros, so the
// group is "full" and the search continues into the next lower group.
module clz_nib (
    input  logic [3:0] nib,
    output logic [2:0] cnt
);

    // Priority encode the first set bit from the nibble MSB downward.
    always_comb begin
        cnt = 3'd4;
        casez (nib)
            4'b1???: cnt = 3'd0;
            4'b01??: cnt = 3'd1;
            4'b001?: cnt = 3'd2;
            4'b0001: cnt = 3'd3;
            default: cnt = 3'd4;
        endcase
    end

endmodule

// File: rtl/clz_pipe.sv
// Two-stage count-leading-zeros / count-leading-sign-bits pipeline with
// valid/ready handshakes on both sides.
//   S1: per-nibble counts of the operand (inverted by its sign in CLS mode).
//   S2: final count, all-zero flag and optional normalised operand.
// Optional feature macro: CLZ_PIPE_NORM_EN enables the normalising shifter
// (out_norm = in_data << out_cnt); without it out_norm is tied to zero and
// no operand is carried past the group encoders.
module clz_pipe
    import clz_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    in_data,
    input  logic                                in_mode,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [clz_cnt_width(WIDTH)-1:0]     out_cnt,
    output logic                                out_zero,
    output logic [WIDTH-1:0]                    out_norm
);

    localparam int CW = clz_cnt_width(WIDTH);
    localparam int NG = WIDTH / 4;

    // Handshake / stage control
    logic             s1_valid_r;
    logic             s2_valid_r;
    logic             s1_adv_s;
    logic             s2_adv_s;

    // Front end: sign-conditioned operand and group counts
    logic             flip_s;
    logic [WIDTH-1:0] inv_s;
    logic [2:0]       grp_s [NG];
    logic [2:0]       s1_grp_r [NG];

    // Back end: priority-combined count
    logic [CW-1:0]    cnt_s;
    logic             done_s;
    logic             zero_s;
    logic [CW-1:0]    s2_cnt_r;
    logic             s2_zero_r;

    // S2 moves when empty or drained; S1 moves when S2 moves or S1 is empty.
    assign s2_adv_s = !s2_valid_r || out_ready;
    assign s1_adv_s = s2_adv_s || !s1_valid_r;
    assign in_ready = s1_adv_s;

    // In CLS mode with a negative operand, inverting turns leading ones into
    // leading zeros so the same encoder serves both modes.
    assign flip_s = (in_mode == CLZ_MODE_CLS) && in_data[WIDTH-1];
    assign inv_s  = in_data ^ {WIDTH{flip_s}};

    genvar g;
    generate
        for (g = 0; g < NG; g++) begin : g_nib
            clz_nib u_nib (
                .nib (inv_s[4*g +: 4]),
                .cnt (grp_s[g])
            );
        end
    endgenerate

    // S1 valid flag: loads the input valid whenever the stage may advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
        end
    end

    // S1 group counts: captured on every accepted word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NG; i++) begin
                s1_grp_r[i] <= 3'd0;
            end
        end else if (s1_adv_s && in_valid) begin
            s1_grp_r <= grp_s;
        end
    end

    // Walk the groups from the most significant one; full groups add 4 and
    // the first non-full group adds its partial count and stops the walk.
    always_comb begin
        cnt_s  = {CW{1'b0}};
        done_s = 1'b0;
        for (int i = NG - 1; i >= 0; i--) begin
            if (!done_s) begin
                cnt_s = cnt_s + CW'(s1_grp_r[i]);
                if (!s1_grp_r[i][2]) begin
                    done_s = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end else begin
                cnt_s = cnt_s;
            end
        end
    end

    assign zero_s = (cnt_s == CW'(WIDTH));

    // S2 valid flag: takes S1's valid whenever S2 may advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
        end
    end

    // S2 count and zero flag: held stable while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_cnt_r  <= {CW{1'b0}};
            s2_zero_r <= 1'b0;
        end else if (s2_adv_s && s1_valid_r) begin
            s2_cnt_r  <= cnt_s;
            s2_zero_r <= zero_s;
        end
    end

    assign out_valid = s2_valid_r;
    assign out_cnt   = s2_cnt_r;
    assign out_zero  = s2_zero_r;

`ifdef CLZ_PIPE_NORM_EN
    // The conditioned operand plus its flip bit lets S2 rebuild the original.
    logic [WIDTH-1:0] s1_op_r;
    logic             s1_flip_r;
    logic [WIDTH-1:0] op_s;
    logic [WIDTH-1:0] norm_s;
    logic [WIDTH-1:0] s2_norm_r;

    // S1 operand carry for the normalising shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_op_r   <= {WIDTH{1'b0}};
            s1_flip_r <= 1'b0;
        end else if (s1_adv_s && in_valid) begin
            s1_op_r   <= inv_s;
            s1_flip_r <= flip_s;
        end
    end

    assign op_s   = s1_op_r ^ {WIDTH{s1_flip_r}};
    assign norm_s = op_s << cnt_s;

    // S2 normalised operand register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_norm_r <= {WIDTH{1'b0}};
        end else if (s2_adv_s && s1_valid_r) begin
            s2_norm_r <= norm_s;
        end
    end

    assign out_norm = s2_norm_r;
`else
    assign out_norm = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_clz_pipe.sv
// Directed self-checking bench for clz_pipe (WIDTH=16 and WIDTH=32 instances).
// Expected normalised values depend on whether CLZ_PIPE_NORM_EN is defined.
module tb_clz_pipe;

`ifdef CLZ_PIPE_NORM_EN
    localparam bit NORM_ON = 1'b1;
`else
    localparam bit NORM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_zero;
    logic [15:0] in_data, out_norm;
    logic [4:0]  out_cnt;

    logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_zero;
    logic [31:0] b_in_data, b_out_norm;
    logic [5:0]  b_out_cnt;

    int n_checks = 0;
    int n_errors = 0;

    clz_pipe #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt),
        .out_zero(out_zero), .out_norm(out_norm)
    );

    clz_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_cnt(b_out_cnt),
        .out_zero(b_out_zero), .out_norm(b_out_norm)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the pipeline empty; returns at a negedge empty.
    task automatic send16(input logic [15:0] d, input logic m, input int c,
                          input logic z, input logic [15:0] n);
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        out_ready = 1'b1;
        #1;
        chk_eq("in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_eq("latency1 out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk_eq("latency2 out_valid", 64'(out_valid), 64'd1);
        chk_eq("out_cnt", 64'(out_cnt), 64'(c));
        chk_eq("out_zero", 64'(out_zero), 64'(z));
        chk_eq("out_norm", 64'(out_norm), NORM_ON ? 64'(n) : 64'd0);
        @(negedge clk);
    endtask

    typedef struct packed {
        logic        m;
        logic [15:0] d;
        logic [4:0]  c;
        logic        z;
        logic [15:0] n;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{m: 1'b0, d: 16'h0001, c: 5'd15, z: 1'b0, n: 16'h8000};
        vecs[1]  = '{m: 1'b0, d: 16'h0000, c: 5'd16, z: 1'b1, n: 16'h0000};
        vecs[2]  = '{m: 1'b1, d: 16'hFFFF, c: 5'd16, z: 1'b1, n: 16'h0000};
        vecs[3]  = '{m: 1'b1, d: 16'hE123, c: 5'd3,  z: 1'b0, n: 16'h0918};
        vecs[4]  = '{m: 1'b1, d: 16'h0F00, c: 5'd4,  z: 1'b0, n: 16'hF000};
        vecs[5]  = '{m: 1'b0, d: 16'h00F0, c: 5'd8,  z: 1'b0, n: 16'hF000};
        vecs[6]  = '{m: 1'b1, d: 16'h7FFF, c: 5'd1,  z: 1'b0, n: 16'hFFFE};
        vecs[7]  = '{m: 1'b0, d: 16'h8000, c: 5'd0,  z: 1'b0, n: 16'h8000};
        vecs[8]  = '{m: 1'b1, d: 16'h8000, c: 5'd1,  z: 1'b0, n: 16'h0000};
        vecs[9]  = '{m: 1'b0, d: 16'h0800, c: 5'd4,  z: 1'b0, n: 16'h8000};
        vecs[10] = '{m: 1'b0, d: 16'h0010, c: 5'd11, z: 1'b0, n: 16'h8000};
        vecs[11] = '{m: 1'b1, d: 16'hFFF7, c: 5'd12, z: 1'b0, n: 16'h7000};
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        int exp_idx;
        int low_cnt;
        int seen;

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = 16'h0000;
        in_mode     = 1'b0;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = 32'h0;
        b_in_mode   = 1'b0;
        b_out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk_eq("reset out_valid", 64'(out_valid), 64'd0);
        chk_eq("reset out_cnt", 64'(out_cnt), 64'd0);
        chk_eq("reset out_zero", 64'(out_zero), 64'd0);
        chk_eq("reset out_norm", 64'(out_norm), 64'd0);
        chk_eq("reset in_ready", 64'(in_ready), 64'd1);

        // Release and present a word for the very first edge after reset
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            send16(vecs[i].d, vecs[i].m, int'(vecs[i].c), vecs[i].z, vecs[i].n);
        end

        // Streaming with a 3-cycle consumer stall
        idx     = 0;
        exp_idx = 0;
        low_cnt = 0;
        for (int cyc = 0; cyc < 40 && exp_idx < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (idx < 8);
            in_data   = 16'h8000 >> idx;
            in_mode   = 1'b0;
            #1;
            if (!in_ready) low_cnt++;
            if (cyc == 3) chk_eq("stall in_ready", 64'(in_ready), 64'd0);
            if (cyc == 4) chk_eq("stall hold cnt", 64'(out_cnt), 64'd1);
            if (out_valid && out_ready) begin
                chk_eq("stream cnt", 64'(out_cnt), 64'(exp_idx));
                exp_idx++;
            end
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk_eq("stream delivered", 64'(exp_idx), 64'd8);
        chk_eq("stall cycles", 64'(low_cnt), 64'd3);
        @(negedge clk);

        // Reset while both stages hold words
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0100;
        @(negedge clk);
        in_data = 16'h0040;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk_eq("full out_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk_eq("async out_valid", 64'(out_valid), 64'd0);
        chk_eq("async out_cnt", 64'(out_cnt), 64'd0);
        chk_eq("async in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        seen      = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk_eq("stale outputs", 64'(seen), 64'd0);
        send16(16'h0004, 1'b0, 13, 1'b0, 16'h8000);

        // 32-bit instance
        b_in_valid = 1'b1;
        b_in_data  = 32'h0001_0000;
        b_in_mode  = 1'b0;
        @(negedge clk);
        b_in_valid = 1'b0;
        @(negedge clk);
        chk_eq("w32 out_valid", 64'(b_out_valid), 64'd1);
        chk_eq("w32 cnt", 64'(b_out_cnt), 64'd15);
        chk_eq("w32 zero", 64'(b_out_zero), 64'd0);
        chk_eq("w32 norm", 64'(b_out_norm), NORM_ON ? 64'h8000_0000 : 64'd0);
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = 32'hFFFF_FFFF;
        b_in_mode  = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        @(negedge clk);
        chk_eq("w32 cls cnt", 64'(b_out_cnt), 64'd32);
        chk_eq("w32 cls zero", 64'(b_out_zero), 64'd1);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
